button_debouncer: RTL and testbench

Conditions a raw mechanical push-button input before it reaches the button edge-detection stage.
- Synchronises the asynchronous pad signal with a 2-FF synchroniser and normalises its polarity.
- Filters contact bounce with a counter-qualified state machine and drives a clean level, o_button.
- Also emits a one-cycle long-press pulse when the debounced press lasts long enough.

---
 rtl/button_debouncer_if.sv | 32 +++
 rtl/button_debouncer.sv | 145 ++++++++++++++
 tb/tb_button_debouncer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// ----------------------------------------------------------------------------
// button_debouncer_if
//   Signal bundle between a raw push-button pad and the debounced consumer.
//
//   i_button_raw  raw asynchronous pad level (driven by the pad side)
//   o_button      debounced level, 1 = pressed
//   o_long_press  one-cycle long-press pulse
//   o_state       debouncer FSM state, for debug
//
//   master : the pad / consumer side (drives the raw level, reads results)
//   slave  : the debouncer itself
// ----------------------------------------------------------------------------
interface button_debouncer_if;
  logic       i_button_raw;
  logic       o_button;
  logic       o_long_press;
  logic [1:0] o_state;

  modport master (
    output i_button_raw,
    input  o_button,
    input  o_long_press,
    input  o_state
  );

  modport slave (
    input  i_button_raw,
    output o_button,
    output o_long_press,
    output o_state
  );
endinterface

// File: rtl/button_debouncer.sv
// ----------------------------------------------------------------------------
// button_debouncer
//   Conditions a raw mechanical push-button before the edge-detect stage:
//   2-FF synchroniser with polarity normalisation, a counter-qualified
//   debounce FSM that drives a clean o_button level, and a one-shot
//   long-press pulse once the debounced press has lasted LONG_CYCLES.
//
//   Ports:
//     i_clk    system clock
//     i_rst_n  synchronous active-low reset
//     bus      button_debouncer_if.slave
//                i_button_raw -> raw pad level (asynchronous)
//                o_button     <- debounced level, 1 = pressed
//                o_long_press <- one-cycle pulse, at most once per press
//                o_state      <- FSM state (debug)
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   RELEASED     | debounced level 0, waiting for a press sample
//   PRESS_WAIT   | press seen, counting stable samples before accepting
//   PRESSED      | debounced level 1, hold counter running
//   RELEASE_WAIT | release seen, counting stable samples; o_button still 1
// ----------------------------------------------------------------------------
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned LONG_CYCLES     = 100000000,
  parameter bit          ACTIVE_HIGH     = 1'b1
) (
  input logic               i_clk,
  input logic               i_rst_n,
  button_debouncer_if.slave bus
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned HOLD_W = $clog2(LONG_CYCLES) + 1;

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] LONG_LAST = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

  // Pad level when the button is not pressed.
  localparam logic REL_LVL = ~ACTIVE_HIGH;

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t            state_q;
  logic              sync1_q;
  logic              sync2_q;
  logic [DB_W-1:0]   db_cnt_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic              long_fired_q;
  logic              button_q;
  logic              long_q;
  logic              s;

  // Synchronised level normalised so that 1 always means pressed.
  assign s = sync2_q ^ REL_LVL;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync1_q      <= REL_LVL;
      sync2_q      <= REL_LVL;
      state_q      <= RELEASED;
      db_cnt_q     <= '0;
      hold_cnt_q   <= '0;
      long_fired_q <= 1'b0;
      button_q     <= 1'b0;
      long_q       <= 1'b0;
    end else begin
      sync1_q <= bus.i_button_raw;
      sync2_q <= sync1_q;
      long_q  <= 1'b0;

      // Hold tracking runs off the registered level, so it keeps counting
      // through RELEASE_WAIT and a pulse due on the release-accept cycle
      // still fires.
      if (button_q) begin
        if (hold_cnt_q != HOLD_MAX) begin
          hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
        end
        if (hold_cnt_q == LONG_LAST && !long_fired_q) begin
          long_q       <= 1'b1;
          long_fired_q <= 1'b1;
        end
      end

      case (state_q)
        RELEASED: begin
          if (s) begin
            state_q  <= PRESS_WAIT;
            db_cnt_q <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state_q  <= RELEASED;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q      <= PRESSED;
            db_cnt_q     <= '0;
            button_q     <= 1'b1;
            hold_cnt_q   <= '0;
            long_fired_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state_q  <= RELEASE_WAIT;
            db_cnt_q <= '0;
          end
        end
        RELEASE_WAIT: begin
          // A bounce back to pressed keeps the hold count intact so the
          // long-press timing does not slip.
          if (s) begin
            state_q  <= PRESSED;
            db_cnt_q <= '0;
          end else if (db_cnt_q == DB_LAST) begin
            state_q  <= RELEASED;
            db_cnt_q <= '0;
            button_q <= 1'b0;
          end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
          end
        end
        default: begin
          state_q  <= RELEASED;
          db_cnt_q <= '0;
        end
      endcase
    end
  end

  assign bus.o_button     = button_q;
  assign bus.o_long_press = long_q;
  assign bus.o_state      = state_q;

endmodule

// File: tb/tb_button_debouncer.sv
// ----------------------------------------------------------------------------
// tb_button_debouncer
//   Two debouncers (active-high and active-low pads, DEBOUNCE_CYCLES=4,
//   LONG_CYCLES=20) share clock and reset. Stimulus pushes the expected
//   output events (edge number of each o_button rise/fall and each
//   o_long_press pulse) into a per-DUT queue; a monitor pops and compares
//   every event the DUTs actually produce.
// ----------------------------------------------------------------------------
module tb_button_debouncer;

  localparam int K_FALL = 0;
  localparam int K_RISE = 1;
  localparam int K_LONG = 2;

  typedef struct {
    int kind;
    int cyc;
  } ev_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  bit   mon_en;
  logic prev_ah;
  logic prev_al;

  ev_t q_ah[$];
  ev_t q_al[$];

  button_debouncer_if ah_if ();
  button_debouncer_if al_if ();

  button_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .ACTIVE_HIGH     (1'b1)
  ) u_ah (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (ah_if)
  );

  button_debouncer #(
    .DEBOUNCE_CYCLES (4),
    .LONG_CYCLES     (20),
    .ACTIVE_HIGH     (1'b0)
  ) u_al (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (al_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int dut, input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    if (dut == 0) q_ah.push_back(e);
    else          q_al.push_back(e);
  endtask

  task automatic sb_check(input int dut, input int kind);
    ev_t   e;
    string nm;
    nm = (dut == 0) ? "ah" : "al";
    n_cmp++;
    if ((dut == 0 && q_ah.size() == 0) || (dut == 1 && q_al.size() == 0)) begin
      n_fail++;
      $display("FAIL %s_unexpected_event: got kind %0d at cycle %0d, expected none",
               nm, kind, cyc);
    end else begin
      e = (dut == 0) ? q_ah.pop_front() : q_al.pop_front();
      if (e.kind != kind || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s_event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                 nm, kind, cyc, e.kind, e.cyc);
      end
    end
  endtask

  // Monitor: every o_button transition and every o_long_press pulse is an event.
  always @(negedge clk) begin
    if (mon_en) begin
      if (ah_if.o_button !== prev_ah) begin
        sb_check(0, (ah_if.o_button === 1'b1) ? K_RISE : K_FALL);
        prev_ah = ah_if.o_button;
      end
      if (ah_if.o_long_press !== 1'b0) sb_check(0, K_LONG);
      if (al_if.o_button !== prev_al) begin
        sb_check(1, (al_if.o_button === 1'b1) ? K_RISE : K_FALL);
        prev_al = al_if.o_button;
      end
      if (al_if.o_long_press !== 1'b0) sb_check(1, K_LONG);
    end
  end

  task automatic to_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    int t;
    n_cmp  = 0;
    n_fail = 0;
    mon_en = 1'b0;
    prev_ah = 1'b0;
    prev_al = 1'b0;
    rst_n  = 1'b0;
    ah_if.i_button_raw = 1'b0;
    al_if.i_button_raw = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_ah_button", int'(ah_if.o_button), 0);
    chk("rst_ah_long",   int'(ah_if.o_long_press), 0);
    chk("rst_ah_state",  int'(ah_if.o_state), 0);
    chk("rst_al_button", int'(al_if.o_button), 0);
    chk("rst_al_state",  int'(al_if.o_state), 0);
    rst_n = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (4) @(negedge clk);

    // Clean press, long press once, release.
    t = cyc;
    ah_if.i_button_raw = 1'b1;
    push(0, K_RISE, t + 7);
    push(0, K_LONG, t + 27);
    to_cyc(t + 2); chk("t1_state_e2", int'(ah_if.o_state), 0);
    to_cyc(t + 3); chk("t1_state_e3", int'(ah_if.o_state), 1);
    to_cyc(t + 6); chk("t1_state_e6", int'(ah_if.o_state), 1);
    to_cyc(t + 7); chk("t1_state_e7", int'(ah_if.o_state), 2);
    to_cyc(t + 130);
    t = cyc;
    ah_if.i_button_raw = 1'b0;
    push(0, K_FALL, t + 7);
    to_cyc(t + 3); chk("t3_state_relwait", int'(ah_if.o_state), 3);
    to_cyc(t + 12); chk("t3_state_released", int'(ah_if.o_state), 0);

    // Bursts 3 high / 2 low: rejected as bounce.
    for (int i = 0; i < 5; i++) begin
      ah_if.i_button_raw = 1'b1;
      @(negedge clk);
      if (i > 0) chk("t2_state_after_burst", int'(ah_if.o_state), 0);
      repeat (2) @(negedge clk);
      ah_if.i_button_raw = 1'b0;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    chk("t2_state_final", int'(ah_if.o_state), 0);
    repeat (10) @(negedge clk);
    chk("t2_button_low", int'(ah_if.o_button), 0);

    // Short release bounce mid-press must not slip the long-press timing.
    t = cyc;
    ah_if.i_button_raw = 1'b1;
    push(0, K_RISE, t + 7);
    push(0, K_LONG, t + 27);
    to_cyc(t + 15); ah_if.i_button_raw = 1'b0;
    to_cyc(t + 17); ah_if.i_button_raw = 1'b1;
    to_cyc(t + 18); chk("t4_state_relwait", int'(ah_if.o_state), 3);
    to_cyc(t + 20); chk("t4_state_repressed", int'(ah_if.o_state), 2);
    to_cyc(t + 40);
    ah_if.i_button_raw = 1'b0;
    push(0, K_FALL, t + 47);
    to_cyc(t + 52);

    // Active-low pad.
    t = cyc;
    al_if.i_button_raw = 1'b0;
    push(1, K_RISE, t + 7);
    to_cyc(t + 10);
    al_if.i_button_raw = 1'b1;
    push(1, K_FALL, t + 17);
    to_cyc(t + 22);
    chk("t5_al_state", int'(al_if.o_state), 0);

    // Reset while pressed: drops at once, full debounce and long count again.
    t = cyc;
    ah_if.i_button_raw = 1'b1;
    push(0, K_RISE, t + 7);
    to_cyc(t + 12);
    rst_n = 1'b0;
    push(0, K_FALL, t + 13);
    @(negedge clk);
    rst_n = 1'b1;
    chk("t6_state_after_rst", int'(ah_if.o_state), 0);
    chk("t6_long_after_rst", int'(ah_if.o_long_press), 0);
    push(0, K_RISE, t + 20);
    push(0, K_LONG, t + 40);
    to_cyc(t + 45);
    ah_if.i_button_raw = 1'b0;
    push(0, K_FALL, t + 52);
    to_cyc(t + 60);

    chk("ah_events_outstanding", q_ah.size(), 0);
    chk("al_events_outstanding", q_al.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
